// File: rtl/blake3_pkg.sv
// blake3_pkg: constants and types shared by the chunk feeder and its
// register-file sub-module.
//   BLK_WORDS / BLK_BYTES : message block geometry (16 x 32-bit = 64 B)
//   CHUNK_BYTES           : maximum chunk length; longer lengths are clamped
//   IV                    : BLAKE3 initial chaining value words
//   feeder_state_t        : chunk_feeder FSM encoding
//   bswap32 / tail_mask   : helpers for byte reversal and final-word masking
package blake3_pkg;

  localparam int BLK_WORDS   = 16;
  localparam int BLK_BYTES   = 64;
  localparam int BLK_SHIFT   = $clog2(BLK_BYTES);
  localparam int CHUNK_BYTES = 1024;

  localparam logic [7:0][31:0] IV = {
    32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
    32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667
  };

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL0  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4
  } feeder_state_t;

  // Reverse the byte order of a 32-bit word.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Byte enables for a word given the bytes still owed to the chunk:
  // four or more keeps the whole word, fewer keeps only the low bytes.
  function automatic logic [3:0] tail_mask(input logic [11:0] rem);
    logic [3:0] m;
    if (rem >= 12'd4) begin
      m = 4'b1111;
    end else begin
      case (rem[1:0])
        2'd3:    m = 4'b0111;
        2'd2:    m = 4'b0011;
        2'd1:    m = 4'b0001;
        default: m = 4'b0000;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/chunk_feeder_block_bank.sv
// block_bank: one 16 x 32-bit message block register file.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   clr        : zero every word and drop the full flag (wins over a write)
//   wr_en      : write wr_data into word wr_idx, bytes with byte_en=0 stored as 0
//   set_full   : mark the block complete
//   full       : block complete flag
//   data       : whole block, word i at bits [32i+31:32i]
module block_bank
  import blake3_pkg::*;
(
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [3:0]   wr_idx,
  input  logic [31:0]  wr_data,
  input  logic [3:0]   byte_en,
  input  logic         set_full,
  output logic         full,
  output logic [511:0] data
);

  logic [BLK_WORDS-1:0][31:0] mem_r;
  logic                       full_r;
  logic [31:0]                masked_s;

  // Zero the bytes that lie beyond the end of the chunk.
  always_comb begin
    masked_s = 32'h0000_0000;
    for (int b = 0; b < 4; b++) begin
      masked_s[8*b +: 8] = byte_en[b] ? wr_data[8*b +: 8] : 8'h00;
    end
  end

  // Block storage and full flag; clearing also zeroes the data so that
  // unwritten words of a short final block read as zero.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mem_r  <= '0;
      full_r <= 1'b0;
    end else if (clr) begin
      mem_r  <= '0;
      full_r <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_r[wr_idx] <= masked_s;
      end
      if (set_full) begin
        full_r <= 1'b1;
      end
    end
  end

  assign full = full_r;
  assign data = mem_r;

endmodule

// File: rtl/chunk_feeder.sv
// chunk_feeder: packs a little-endian 32-bit word stream into 64-byte
// message blocks for the chunk hasher, zero-padding the tail, and serves
// the hasher's Next pulses from a ping-pong pair of block banks.
//   Clk, Rst_n            : clock, asynchronous active-low reset
//   Len_I, Len_Vld_I      : chunk length (bytes, clamped to 1024) and start strobe
//   Word_I, Word_Vld_I,
//   Word_Rdy_O            : message word stream, transfer on Vld & Rdy
//   Next_I                : hasher has consumed the current block
//   Update_O              : one-cycle pulse, block 0 ready, new chunk
//   Msg_O                 : current message block (word i at [32i+31:32i])
//   Byte_num_O            : latched chunk length
//   Busy_O                : chunk in progress
//   Underrun_O            : sticky, Next_I arrived before the next block was full
// Build option: define CHUNK_FEEDER_BSWAP_EN to byte-reverse every accepted
// word before storage (big-endian input); length masking then applies to
// the swapped byte order.
module chunk_feeder
  import blake3_pkg::*;
(
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic [10:0]  Len_I,
  input  logic         Len_Vld_I,
  input  logic [31:0]  Word_I,
  input  logic         Word_Vld_I,
  output logic         Word_Rdy_O,
  input  logic         Next_I,
  output logic         Update_O,
  output logic [511:0] Msg_O,
  output logic [10:0]  Byte_num_O,
  output logic         Busy_O,
  output logic         Underrun_O
);

  feeder_state_t state_r, state_nx;

  logic [10:0]  len_r;
  logic [4:0]   nblk_r;
  logic [8:0]   nwords_r;
  logic [8:0]   wcnt_r;
  logic [4:0]   served_r;
  logic         rd_bank_r;
  logic         update_r;
  logic         busy_r;
  logic         underrun_r;

  logic [10:0]  len_clamp_s;
  logic [11:0]  len_ext_s;
  logic [8:0]   nwords_s;
  logic [4:0]   nblk_raw_s;
  logic [4:0]   nblk_s;
  logic [11:0]  rem_s;
  logic [3:0]   byte_en_s;
  logic [31:0]  wr_word_s;

  logic         start_s;
  logic         wr_bank_s;
  logic         words_left_s;
  logic         last_word_s;
  logic         word_rdy_s;
  logic         xfer_s;
  logic         complete_s;
  logic         next_s;
  logic         end_s;
  logic         adv_s;

  logic [1:0]   clr_s;
  logic [1:0]   wr_en_s;
  logic [1:0]   set_full_s;
  logic [1:0]   full_s;
  logic [511:0] data0_s;
  logic [511:0] data1_s;

  // Length decode: clamp, then word and block counts (an empty chunk still
  // sends one all-zero block).
  always_comb begin
    len_clamp_s = (Len_I > 11'(CHUNK_BYTES)) ? 11'(CHUNK_BYTES) : Len_I;
    len_ext_s   = {1'b0, len_clamp_s};
    nwords_s    = 9'((len_ext_s + 12'd3) >> 2);
    nblk_raw_s  = 5'((len_ext_s + 12'(BLK_BYTES - 1)) >> BLK_SHIFT);
    nblk_s      = (nblk_raw_s == 5'd0) ? 5'd1 : nblk_raw_s;
  end

  // Handshake and bank-control decode.  Block k always lands in bank k[0],
  // so the write bank is simply bit 4 of the accepted-word count.
  always_comb begin
    start_s      = (state_r == ST_IDLE) && Len_Vld_I;
    wr_bank_s    = wcnt_r[4];
    words_left_s = (wcnt_r != nwords_r);
    last_word_s  = (wcnt_r == (nwords_r - 9'd1));
    word_rdy_s   = ((state_r == ST_FILL0) || (state_r == ST_STREAM)) &&
                   !full_s[wr_bank_s] && words_left_s;
    xfer_s       = word_rdy_s && Word_Vld_I;
    complete_s   = xfer_s && ((wcnt_r[3:0] == 4'd15) || last_word_s);
    next_s       = Next_I && ((state_r == ST_ISSUE) || (state_r == ST_STREAM) ||
                              (state_r == ST_DRAIN));
    end_s        = next_s && (served_r == (nblk_r - 5'd1));
    adv_s        = next_s && !end_s;

    rem_s        = len_ext_s - {1'b0, wcnt_r, 2'b00};
    byte_en_s    = tail_mask(rem_s);
`ifdef CHUNK_FEEDER_BSWAP_EN
    wr_word_s    = bswap32(Word_I);
`else
    wr_word_s    = Word_I;
`endif

    clr_s[0]      = start_s || (adv_s && !rd_bank_r);
    clr_s[1]      = start_s || (adv_s && rd_bank_r);
    wr_en_s[0]    = xfer_s && !wr_bank_s;
    wr_en_s[1]    = xfer_s && wr_bank_s;
    set_full_s[0] = (complete_s && !wr_bank_s) ||
                    ((state_r == ST_FILL0) && (nwords_r == 9'd0));
    set_full_s[1] = complete_s && wr_bank_s;
  end

  block_bank u_bank0 (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .clr      (clr_s[0]),
    .wr_en    (wr_en_s[0]),
    .wr_idx   (wcnt_r[3:0]),
    .wr_data  (wr_word_s),
    .byte_en  (byte_en_s),
    .set_full (set_full_s[0]),
    .full     (full_s[0]),
    .data     (data0_s)
  );

  block_bank u_bank1 (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .clr      (clr_s[1]),
    .wr_en    (wr_en_s[1]),
    .wr_idx   (wcnt_r[3:0]),
    .wr_data  (wr_word_s),
    .byte_en  (byte_en_s),
    .set_full (set_full_s[1]),
    .full     (full_s[1]),
    .data     (data1_s)
  );

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nx = ST_FILL0;
        else         state_nx = ST_IDLE;
      end
      ST_FILL0: begin
        if ((nwords_r == 9'd0) || complete_s) state_nx = ST_ISSUE;
        else                                  state_nx = ST_FILL0;
      end
      ST_ISSUE: begin
        if (end_s) state_nx = ST_IDLE;
        else       state_nx = ST_STREAM;
      end
      ST_STREAM: begin
        if (end_s)                                       state_nx = ST_IDLE;
        else if (!words_left_s || (xfer_s && last_word_s)) state_nx = ST_DRAIN;
        else                                             state_nx = ST_STREAM;
      end
      ST_DRAIN: begin
        if (end_s) state_nx = ST_IDLE;
        else       state_nx = ST_DRAIN;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register, chunk counters and registered status outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r    <= ST_IDLE;
      len_r      <= 11'd0;
      nblk_r     <= 5'd0;
      nwords_r   <= 9'd0;
      wcnt_r     <= 9'd0;
      served_r   <= 5'd0;
      rd_bank_r  <= 1'b0;
      update_r   <= 1'b0;
      busy_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r  <= state_nx;
      update_r <= (state_nx == ST_ISSUE);
      busy_r   <= (state_nx != ST_IDLE);
      if (start_s) begin
        len_r      <= len_clamp_s;
        nblk_r     <= nblk_s;
        nwords_r   <= nwords_s;
        wcnt_r     <= 9'd0;
        served_r   <= 5'd0;
        rd_bank_r  <= 1'b0;
        underrun_r <= 1'b0;
      end else begin
        if (xfer_s) begin
          wcnt_r <= wcnt_r + 9'd1;
        end
        if (adv_s) begin
          served_r  <= served_r + 5'd1;
          rd_bank_r <= !rd_bank_r;
          // The pointer still moves on an underrun; the flag records it.
          if (!full_s[!rd_bank_r]) begin
            underrun_r <= 1'b1;
          end
        end
      end
    end
  end

  // The hasher samples Msg_O in the cycle it raises Next, so the outgoing
  // block is bypassed to the incoming bank immediately.  The final Next of a
  // chunk does not move the pointer and so does not switch the view.
  assign Msg_O      = (rd_bank_r ^ adv_s) ? data1_s : data0_s;
  assign Word_Rdy_O = word_rdy_s;
  assign Update_O   = update_r;
  assign Byte_num_O = len_r;
  assign Busy_O     = busy_r;
  assign Underrun_O = underrun_r;

endmodule

// File: tb/tb_chunk_feeder.sv
module tb_chunk_feeder;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic [10:0]  Len_I;
  logic         Len_Vld_I;
  logic [31:0]  Word_I;
  logic         Word_Vld_I;
  logic         Word_Rdy_O;
  logic         Next_I;
  logic         Update_O;
  logic [511:0] Msg_O;
  logic [10:0]  Byte_num_O;
  logic         Busy_O;
  logic         Underrun_O;

  chunk_feeder dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Len_I      (Len_I),
    .Len_Vld_I  (Len_Vld_I),
    .Word_I     (Word_I),
    .Word_Vld_I (Word_Vld_I),
    .Word_Rdy_O (Word_Rdy_O),
    .Next_I     (Next_I),
    .Update_O   (Update_O),
    .Msg_O      (Msg_O),
    .Byte_num_O (Byte_num_O),
    .Busy_O     (Busy_O),
    .Underrun_O (Underrun_O)
  );

  always #5 Clk = ~Clk;

  int           n_vec = 0;
  int           n_err = 0;
  logic [511:0] exp_q[$];
  logic [31:0]  wq [0:255];
  int           words_sent = 0;
  int           upd_cnt = 0;
  bit           nxt_chk = 1'b0;
  bit           rdy_seen = 1'b0;
  bit           hold_pend = 1'b0;
  logic [511:0] hold_msg;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout/empty expected event", name);
  endtask

  function automatic logic [31:0] feed(input logic [31:0] w);
`ifdef CHUNK_FEEDER_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [511:0] mk_block(input int k);
    logic [511:0] b;
    b = '0;
    for (int j = 0; j < 16; j++) b[32*j +: 32] = wq[16*k + j];
    return b;
  endfunction

  task automatic pop_cmp(input string name);
    if (exp_q.size() == 0) flag_fail({name, "_unexpected"});
    else chk(name, Msg_O, exp_q.pop_front());
  endtask

  // Monitor: compares presented blocks against the scoreboard queue.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (Word_Rdy_O) rdy_seen = 1'b1;
      if (hold_pend) begin
        chk("upd_hold", Msg_O, hold_msg);
        hold_pend = 1'b0;
      end
      if (Update_O) begin
        upd_cnt++;
        hold_msg  = Msg_O;
        hold_pend = 1'b1;
        pop_cmp("upd_blk");
      end
      if (Next_I && nxt_chk) pop_cmp("next_blk");
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic start(input logic [10:0] len);
    @(posedge Clk); #1;
    Len_I = len; Len_Vld_I = 1'b1;
    @(posedge Clk); #1;
    Len_Vld_I = 1'b0;
  endtask

  task automatic send(input int from, input int to);
    bit r;
    int g;
    @(posedge Clk); #1;
    for (int i = from; i < to; i++) begin
      Word_I = feed(wq[i]); Word_Vld_I = 1'b1;
      g = 0;
      forever begin
        @(negedge Clk); r = Word_Rdy_O;
        @(posedge Clk); #1;
        if (r) break;
        g++;
        if (g > 1000) break;
      end
      if (!r) begin
        flag_fail("send_rdy");
        break;
      end
      words_sent = i + 1;
    end
    Word_Vld_I = 1'b0;
  endtask

  task automatic pulse_next(input bit c);
    @(posedge Clk); #1;
    Next_I = 1'b1; nxt_chk = c;
    @(posedge Clk); #1;
    Next_I = 1'b0; nxt_chk = 1'b0;
  endtask

  task automatic wait_upd(input int u0, input string name);
    int g = 0;
    while (upd_cnt == u0 && g < 400) begin
      @(posedge Clk); #1; g++;
    end
    if (upd_cnt == u0) flag_fail(name);
  endtask

  task automatic wait_words(input int tgt);
    int g = 0;
    while (words_sent < tgt && g < 3000) begin
      @(posedge Clk); #1; g++;
    end
    if (words_sent < tgt) flag_fail("wait_words");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] b2;
    int u0;
    int k;
    Rst_n = 1'b0; Len_I = 11'd0; Len_Vld_I = 1'b0; Word_I = 32'd0;
    Word_Vld_I = 1'b0; Next_I = 1'b0;
    repeat (3) @(posedge Clk); #1;
    chk("rst_outs", {Word_Rdy_O, Update_O, Busy_O, Underrun_O, Byte_num_O}, 15'd0);
    chk("rst_msg", Msg_O, 512'd0);
    Rst_n = 1'b1;
    cycles(2);

    // 1: len=64, words 0..15
    for (int i = 0; i < 256; i++) wq[i] = 32'(i);
    exp_q.push_back(mk_block(0));
    u0 = upd_cnt;
    start(11'd64);
    chk("t1_busy", Busy_O, 512'd1);
    send(0, 16);
    wait_upd(u0, "t1_update");
    chk("t1_bytenum", Byte_num_O, 512'd64);
    cycles(2);
    pulse_next(1'b0);
    cycles(1);
    chk("t1_idle", {Busy_O, Underrun_O}, 512'd0);

    // 2: len=130, 33 words, three Nexts 60 cycles apart
    for (int i = 0; i < 256; i++) wq[i] = 32'hC0DE_0000 | 32'(i);
    b2 = '0;
    b2[31:0] = 32'h0000_0020;
    exp_q.push_back(mk_block(0));
    exp_q.push_back(mk_block(1));
    exp_q.push_back(b2);
    u0 = upd_cnt;
    start(11'd130);
    fork
      send(0, 33);
      begin
        wait_upd(u0, "t2_update");
        cycles(60); pulse_next(1'b1);
        cycles(60); pulse_next(1'b1);
        cycles(60); pulse_next(1'b0);
      end
    join
    cycles(1);
    chk("t2_idle", {Busy_O, Underrun_O}, 512'd0);
    chk("t2_q_empty", 512'(exp_q.size()), 512'd0);

    // 3: len=0
    exp_q.push_back(512'd0);
    rdy_seen = 1'b0;
    u0 = upd_cnt;
    start(11'd0);
    k = 0;
    while (upd_cnt == u0 && k < 20) begin
      @(posedge Clk); #1; k++;
    end
    chk("t3_upd_latency", 512'(k), 512'd2);
    chk("t3_bytenum", Byte_num_O, 512'd0);
    cycles(2);
    pulse_next(1'b0);
    cycles(1);
    chk("t3_idle", Busy_O, 512'd0);
    chk("t3_no_rdy", 512'(rdy_seen), 512'd0);

    // 4: len=256, stall after 20 words, early Next -> underrun
    for (int i = 0; i < 256; i++) wq[i] = 32'h1357_0000 + 32'(i * 3);
    exp_q.push_back(mk_block(0));
    u0 = upd_cnt;
    start(11'd256);
    send(0, 20);
    wait_upd(u0, "t4_update");
    chk("t4_no_underrun_yet", Underrun_O, 512'd0);
    cycles(5);
    pulse_next(1'b0);
    chk("t4_underrun", {Busy_O, Underrun_O}, 512'd3);
    fork
      send(20, 64);
      begin
        cycles(40); pulse_next(1'b0);
        cycles(40); pulse_next(1'b0);
        cycles(40); pulse_next(1'b0);
      end
    join
    cycles(1);
    chk("t4_sticky", {Busy_O, Underrun_O}, 512'd1);

    // 5: Len_I=1100 clamps to 1024, back-to-back words, Next every 4 cycles
    for (int i = 0; i < 256; i++) wq[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A00_00A5;
    for (int b = 0; b < 16; b++) exp_q.push_back(mk_block(b));
    u0 = upd_cnt;
    words_sent = 0;
    start(11'd1100);
    chk("t5_underrun_clr", Underrun_O, 512'd0);
    chk("t5_bytenum", Byte_num_O, 512'd1024);
    fork
      send(0, 256);
      begin
        wait_upd(u0, "t5_update");
        for (int b = 1; b < 16; b++) begin
          wait_words((16 * (b + 1) > 256) ? 256 : 16 * (b + 1));
          cycles(4);
          pulse_next(1'b1);
        end
        cycles(4);
        pulse_next(1'b0);
      end
    join
    cycles(1);
    chk("t5_idle", {Busy_O, Underrun_O}, 512'd0);
    chk("t5_q_empty", 512'(exp_q.size()), 512'd0);

    // 6: reset mid-STREAM, then a normal len=64 chunk
    for (int i = 0; i < 256; i++) wq[i] = 32'hA5A5_0000 | 32'(i);
    exp_q.push_back(mk_block(0));
    u0 = upd_cnt;
    start(11'd256);
    send(0, 24);
    chk("t6_streaming", Busy_O, 512'd1);
    chk("t6_upd_seen", 512'(upd_cnt - u0), 512'd1);
    @(posedge Clk); #2;
    Rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {Word_Rdy_O, Update_O, Busy_O, Underrun_O, Byte_num_O}, 15'd0);
    chk("t6_rst_msg", Msg_O, 512'd0);
    cycles(2);
    Rst_n = 1'b1;
    cycles(1);
    exp_q.push_back(mk_block(0));
    u0 = upd_cnt;
    start(11'd64);
    send(0, 16);
    wait_upd(u0, "t6_update");
    cycles(2);
    pulse_next(1'b0);
    cycles(1);
    chk("t6_idle", {Busy_O, Underrun_O}, 512'd0);
    chk("t6_q_empty", 512'(exp_q.size()), 512'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
